// File: rtl/pla__ts10_pkg.sv
// Purpose: shared widths, FSM state type and helpers for the rotate sequencer.
//   rails(step) : dual-rail select pattern {~step, step} placed above the data word
//   rotl16      : reference 16-bit left rotate
package pla__ts10_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned RAIL_W = 22;
  localparam int unsigned PASS_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Complement rail on top, true rail below; 000/000 is the null code.
  function automatic logic [2*SEL_W-1:0] rails(input logic [SEL_W-1:0] step);
    return {~step, step};
  endfunction

  function automatic logic [DATA_W-1:0] rotl16(input logic [DATA_W-1:0] data,
                                               input logic [AMT_W-1:0]  amt);
    logic [2*DATA_W-1:0] dd;
    dd = {data, data} << amt;
    return dd[2*DATA_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/pla__ts10_rot_seq_if.sv
// Purpose: request/response handshake bundle of the rotate sequencer.
//   in_valid/in_ready/in_data/in_amt        : request channel
//   out_valid/out_ready/out_data/out_passes : response channel
//   master = requester/consumer side, slave = sequencer side.
interface pla__ts10_rot_seq_if;
  import pla__ts10_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PASS_W-1:0] out_passes;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_passes
  );

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_passes
  );

endinterface

// File: rtl/pla__ts10_step_sel.sv
// Purpose: pick the next rotate step from the remaining amount (combinational).
//   i_rem          : remaining rotate amount
//   o_step_c       : min(i_rem, MAX_STEP)
//   o_rem_next_c   : i_rem - o_step_c (never underflows)
//   o_last_c       : this pass finishes the rotation
module pla__ts10_step_sel
  import pla__ts10_pkg::*;
#(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic [AMT_W-1:0] i_rem,
  output logic [SEL_W-1:0] o_step_c,
  output logic [AMT_W-1:0] o_rem_next_c,
  output logic             o_last_c
);

  localparam logic [AMT_W-1:0] MAX_A = AMT_W'(MAX_STEP);

  logic w_clip;

  always_comb begin
    w_clip       = (i_rem > MAX_A);
    // Unclipped i_rem is <= MAX_STEP <= 7, so the low bits hold it exactly.
    o_step_c     = w_clip ? SEL_W'(MAX_STEP) : i_rem[SEL_W-1:0];
    o_rem_next_c = i_rem - AMT_W'(o_step_c);
    o_last_c     = (o_rem_next_c == '0);
  end

endmodule

// File: rtl/pla__ts10_rot_seq.sv
// Purpose: splits a 0..15 left rotate into passes of at most MAX_STEP through an
//   external 16-bit dual-rail rotator, feeding each result back until done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response handshake (slave side)
//   rot_x    : to rotator, {~step, step, data}; all zero outside ISSUE
//   rot_z    : rotator result, combinational from rot_x
// MAX_STEP must be 5..7 so that at most three passes fit in out_passes.
module pla__ts10_rot_seq
  import pla__ts10_pkg::*;
#(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic                clk,
  input  logic                rst,
  pla__ts10_rot_seq_if.slave  bus,
  output logic [RAIL_W-1:0]   rot_x,
  input  logic [DATA_W-1:0]   rot_z
);

  state_e            r_state;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_rem;
  logic [PASS_W-1:0] r_passes;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [PASS_W-1:0] r_out_passes;

  logic [SEL_W-1:0]  w_step;
  logic [AMT_W-1:0]  w_rem_next;
  logic              w_last;

  pla__ts10_step_sel #(
    .MAX_STEP (MAX_STEP)
  ) u_step_sel (
    .i_rem        (r_rem),
    .o_step_c     (w_step),
    .o_rem_next_c (w_rem_next),
    .o_last_c     (w_last)
  );

  // Rails are null outside ISSUE so the rotator idles at zero; decoded from
  // state so an async reset clears them immediately.
  always_comb begin
    rot_x = '0;
    if (r_state == ISSUE) begin
      rot_x = {rails(w_step), r_data};
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_rem        <= '0;
      r_passes     <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_passes <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_data     <= bus.in_data;
            r_rem      <= bus.in_amt;
            r_passes   <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_data   <= rot_z;
          r_rem    <= w_rem_next;
          r_passes <= r_passes + PASS_W'(1);
          if (w_last) begin
            r_out_data   <= rot_z;
            r_out_passes <= r_passes + PASS_W'(1);
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_passes = r_out_passes;

endmodule
